// File: rtl/accel_pair_scheduler_if.sv
// Pipeline-side bus of the pair scheduler: operands out to the fixed-latency
// acceleration pipeline, results back in, and the tagged result stream out
// to the downstream accumulator.
interface accel_pair_scheduler_if #(
    parameter int IDXW = 6
);
    logic              p_valid;
    logic [63:0]       p_x1;
    logic [63:0]       p_y1;
    logic [63:0]       p_x2;
    logic [63:0]       p_y2;
    logic [63:0]       p_m2;
    logic [63:0]       p_ax;
    logic [63:0]       p_ay;
    logic              res_valid;
    logic [IDXW-1:0]   res_idx;
    logic              res_first;
    logic              res_last;
    logic [63:0]       res_ax;
    logic [63:0]       res_ay;

    // Scheduler side
    modport master (
        output p_valid, p_x1, p_y1, p_x2, p_y2, p_m2,
        input  p_ax, p_ay,
        output res_valid, res_idx, res_first, res_last, res_ax, res_ay
    );

    // Pipeline / accumulator side
    modport slave (
        input  p_valid, p_x1, p_y1, p_x2, p_y2, p_m2,
        output p_ax, p_ay,
        input  res_valid, res_idx, res_first, res_last, res_ax, res_ay
    );
endinterface

// File: rtl/accel_pair_scheduler.sv
// Pair scheduler feeding the pairwise acceleration pipeline. Walks every
// ordered pair (i, j), i != j, one per cycle, and carries {valid, i, first,
// last} tags alongside the pipeline so each returning ax/ay is re-associated
// with its target body. The pipeline cannot stall; the issue schedule is the
// only flow control.
module accel_pair_scheduler #(
    parameter int MAX_BODIES = 64,
    parameter int IDXW       = $clog2(MAX_BODIES),
    parameter int PIPE_LAT   = 122
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [IDXW:0]          n_bodies,
    output logic                   busy,
    output logic                   done,
    output logic [IDXW-1:0]        ra_addr,
    input  logic [63:0]            ra_x,
    input  logic [63:0]            ra_y,
    output logic [IDXW-1:0]        rb_addr,
    input  logic [63:0]            rb_x,
    input  logic [63:0]            rb_y,
    input  logic [63:0]            rb_m,
    accel_pair_scheduler_if.master pif
);

    localparam int            IW1    = IDXW + 1;
    localparam logic [IDXW:0] MAX_N  = IW1'(MAX_BODIES);
    localparam logic [IDXW:0] N_ONE  = IW1'(1);
    localparam logic [IDXW:0] N_TWO  = IW1'(2);
    localparam logic [IDXW-1:0] I_ZERO = IDXW'(0);
    localparam logic [IDXW-1:0] I_ONE  = IDXW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          state_r, state_next_s;
    logic [IDXW:0]   n_r, n_next_s;
    logic [IDXW-1:0] i_r, i_next_s;
    logic [IDXW-1:0] j_r, j_next_s;
    logic            busy_r, done_r;

    logic [IDXW:0]   n_clamp_s;
    logic [IDXW:0]   j_inc_s;
    logic [IDXW:0]   j_skip_s;
    logic            row_end_s;
    logic            last_row_s;
    logic            last_pair_s;
    logic            issue_s;
    logic            first_s;
    logic            last_s;
    logic            pending_s;

    // Stage-1 tag register, aligned with the one-cycle RAM read
    logic            s1_valid_r;
    logic [IDXW-1:0] s1_idx_r;
    logic            s1_first_r;
    logic            s1_last_r;

    // Tag delay line matching the pipeline latency
    logic            dl_valid_r [PIPE_LAT];
    logic [IDXW-1:0] dl_idx_r   [PIPE_LAT];
    logic            dl_first_r [PIPE_LAT];
    logic            dl_last_r  [PIPE_LAT];

    // Pair-walk arithmetic: clamp, skip-self increment and row/first/last decode
    always_comb begin
        n_clamp_s   = (n_bodies > MAX_N) ? MAX_N : n_bodies;
        j_inc_s     = {1'b0, j_r} + N_ONE;
        j_skip_s    = (j_inc_s == {1'b0, i_r}) ? (j_inc_s + N_ONE) : j_inc_s;
        row_end_s   = (j_skip_s >= n_r);
        last_row_s  = ({1'b0, i_r} == (n_r - N_ONE));
        last_pair_s = row_end_s && last_row_s;
        first_s     = (i_r == I_ZERO) ? (j_r == I_ONE) : (j_r == I_ZERO);
        if (last_row_s) begin
            last_s = ({1'b0, j_r} == (n_r - N_TWO));
        end else begin
            last_s = ({1'b0, j_r} == (n_r - N_ONE));
        end
    end

    // Tags still in flight after this edge; the output stage is excluded so
    // done lands the cycle right after the final result
    always_comb begin
        pending_s = s1_valid_r;
        for (int k = 0; k < PIPE_LAT - 1; k++) begin
            pending_s = pending_s | dl_valid_r[k];
        end
    end

    // FSM next-state and counter update
    always_comb begin
        state_next_s = state_r;
        n_next_s     = n_r;
        i_next_s     = i_r;
        j_next_s     = j_r;
        issue_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    n_next_s = n_clamp_s;
                    i_next_s = I_ZERO;
                    j_next_s = I_ONE;
                    if (n_clamp_s < N_TWO) begin
                        state_next_s = ST_DRAIN;
                    end else begin
                        state_next_s = ST_ISSUE;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                issue_s = 1'b1;
                if (last_pair_s) begin
                    state_next_s = ST_DRAIN;
                    i_next_s     = I_ZERO;
                    j_next_s     = I_ZERO;
                end else if (row_end_s) begin
                    i_next_s = i_r + I_ONE;
                    j_next_s = ((i_r + I_ONE) == I_ZERO) ? I_ONE : I_ZERO;
                end else begin
                    j_next_s = j_skip_s[IDXW-1:0];
                end
            end
            ST_DRAIN: begin
                if (!pending_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, counters and registered status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            n_r     <= '0;
            i_r     <= '0;
            j_r     <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            n_r     <= n_next_s;
            i_r     <= i_next_s;
            j_r     <= j_next_s;
            busy_r  <= (state_next_s != ST_IDLE);
            done_r  <= (state_next_s == ST_DONE);
        end
    end

    // Stage-1 tag capture alongside the RAM read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_r <= 1'b0;
            s1_idx_r   <= '0;
            s1_first_r <= 1'b0;
            s1_last_r  <= 1'b0;
        end else begin
            s1_valid_r <= issue_s;
            s1_idx_r   <= i_r;
            s1_first_r <= first_s;
            s1_last_r  <= last_s;
        end
    end

    // Tag delay line, advancing every cycle in lockstep with the pipeline
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < PIPE_LAT; k++) begin
                dl_valid_r[k] <= 1'b0;
                dl_idx_r[k]   <= '0;
                dl_first_r[k] <= 1'b0;
                dl_last_r[k]  <= 1'b0;
            end
        end else begin
            dl_valid_r[0] <= s1_valid_r;
            dl_idx_r[0]   <= s1_idx_r;
            dl_first_r[0] <= s1_first_r;
            dl_last_r[0]  <= s1_last_r;
            for (int k = 1; k < PIPE_LAT; k++) begin
                dl_valid_r[k] <= dl_valid_r[k-1];
                dl_idx_r[k]   <= dl_idx_r[k-1];
                dl_first_r[k] <= dl_first_r[k-1];
                dl_last_r[k]  <= dl_last_r[k-1];
            end
        end
    end

    assign busy          = busy_r;
    assign done          = done_r;
    assign ra_addr       = i_r;
    assign rb_addr       = j_r;

    assign pif.p_valid   = s1_valid_r;
    assign pif.p_x1      = ra_x;
    assign pif.p_y1      = ra_y;
    assign pif.p_x2      = rb_x;
    assign pif.p_y2      = rb_y;
    assign pif.p_m2      = rb_m;

    assign pif.res_valid = dl_valid_r[PIPE_LAT-1];
    assign pif.res_idx   = dl_idx_r[PIPE_LAT-1];
    assign pif.res_first = dl_first_r[PIPE_LAT-1];
    assign pif.res_last  = dl_last_r[PIPE_LAT-1];
    assign pif.res_ax    = pif.p_ax;
    assign pif.res_ay    = pif.p_ay;

endmodule

// File: doc/accel_pair_scheduler.md
Name: accel_pair_scheduler

Overview:
- Sequencer on the feeding side of the fixed-latency pairwise acceleration pipeline. It walks every ordered body pair (i, j) with i != j from a dual-port body RAM and drives positions and mass into the pipeline, one pair per cycle.
- It carries per-pair tags alongside the pipeline and re-associates each returning ax/ay with its target body. Per-body first/last markers go to the downstream accumulator.
- The pipeline cannot stall, so the only flow control is the issue schedule.

Parameters:
- MAX_BODIES, 64, maximum body count; RAM depth.
- IDXW, $clog2(MAX_BODIES), body index width.
- PIPE_LAT, 122, pipeline latency in cycles from p_valid to matching p_ax/p_ay; must equal the instantiated pipeline's latency.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- start  in  1  one-cycle run request
- n_bodies  in  IDXW+1  body count, sampled at accepted start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at run completion
- ra_addr  out  IDXW  RAM port A address (body i)
- ra_x, ra_y  in  64  body i position, 1-cycle read latency
- rb_addr  out  IDXW  RAM port B address (body j)
- rb_x, rb_y, rb_m  in  64  body j position and G-premultiplied mass, 1-cycle read latency
- p_valid  out  1  pair presented to pipeline this cycle
- p_x1, p_y1, p_x2, p_y2, p_m2  out  64  pipeline operands
- p_ax, p_ay  in  64  pipeline results
- res_valid  out  1  result for a real pair
- res_idx  out  IDXW  target body i of result
- res_first, res_last  out  1  first/last result for res_idx
- res_ax, res_ay  out  64  combinational pass-through of p_ax/p_ay

Behaviour:
- Reset: asynchronous clear of the FSM, i/j counters and all tag stages. Outputs after reset: state IDLE, busy=0, done=0, p_valid=0, res_valid=0, addresses=0. Reset mid-run aborts the run; in-flight tags are dropped, so no res_valid is produced for them.
- FSM states:
  - IDLE: start=1 latches n = min(n_bodies, MAX_BODIES). If n<2 go to DRAIN with no issues; else go to ISSUE with i=0, j=1. start is ignored while busy.
  - ISSUE: drives ra_addr=i and rb_addr=j every cycle, with no bubbles. The next j skips i: j+1, or j+2 if j+1==i. When the next j would be >= n, set i=i+1 and j=(i+1==0 ? 1 : 0). After pair (n-1, n-2) has issued, go to DRAIN.
  - DRAIN: wait until all tag stages are empty (no valid in stage-1 register or delay line), then go to DONE.
  - DONE: done=1 for one cycle, busy=0 from the next cycle, return to IDLE.
- Issue order: i-major, j ascending; n*(n-1) pairs total.
- Stage-1 register (matches RAM latency): captures issue-valid, i, first (j is the lowest j != i), last (j is the highest j != i).
  - p_valid = stage-1 valid.
  - p_x1=ra_x, p_y1=ra_y, p_x2=rb_x, p_y2=rb_y, p_m2=rb_m.
- Tag delay line: PIPE_LAT stages of {valid, i, first, last}, fed from stage-1 and advancing every cycle.
  - Output stage drives res_valid, res_idx, res_first, res_last.
  - res_valid is exactly p_valid delayed by PIPE_LAT.
- Timing:
  - Start accepted at edge E0: first addresses driven during cycle E0→E1, first p_valid during E1→E2, first res_valid PIPE_LAT cycles later.
  - done pulses the cycle after the final res_valid (res_last=1 for i=n-1).
  - For n<2, done pulses 2 cycles after the accepted start.
- A start arriving on the same cycle as done is ignored. A new start is accepted the cycle after done.
- Data outputs carry don't-care values when their valid is low. Consumers must qualify on p_valid/res_valid.

Test Plan:
- n=3, PIPE_LAT=4, stub pipeline with p_ax = delayed p_x2 → p_valid for 6 consecutive cycles with pairs (0,1),(0,2),(1,0),(1,2),(2,0),(2,1). res_idx sequence is 0,0,1,1,2,2 with first on the 1st/3rd/5th results and last on the 2nd/4th/6th. done pulses 1 cycle after the 6th result; busy is high for the whole run.
- n=1 and n=0 → no p_valid and no res_valid; done pulses 2 cycles after start.
- n=5, with start pulsed again mid-run → exactly 20 results; the second start has no effect.
- rst driven low at the 3rd issue cycle of an n=4 run → all outputs 0 immediately (asynchronously). No res_valid appears afterwards, and the next run with n=2 produces exactly 2 results.
- n_bodies=MAX_BODIES+5 → clamped; exactly MAX_BODIES*(MAX_BODIES-1) results, and the last pair is (MAX_BODIES-1, MAX_BODIES-2).
- Back-to-back runs with n=2, with start asserted the cycle after done → second run accepted; 2 results per run, and each run's done is correctly timed.
